// File: rtl/div_issue_ctrl.sv
// Issue/response controller between execute and the multicycle divider.
// Resolves divide-by-zero and signed overflow locally and reuses the last quotient/remainder pair.
//
// state   | meaning
// S_IDLE  | ready for a request
// S_ISSUE | operands registered, start pulse to divider this cycle
// S_WAIT  | divider busy, result will be returned
// S_DRAIN | op was flushed, divider still busy; result only refreshes the cache
// S_RESP  | result held until the consumer takes it
module div_issue_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CACHE_EN       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [DATA_WIDTH-1:0]     req_rs1,
    input  logic [DATA_WIDTH-1:0]     req_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic [REG_ADDR_WIDTH-1:0] resp_rd,
    output logic                      div_start,
    output logic [DATA_WIDTH-1:0]     div_dividend,
    output logic [DATA_WIDTH-1:0]     div_divisor,
    output logic                      div_signed,
    input  logic [DATA_WIDTH-1:0]     div_quotient,
    input  logic [DATA_WIDTH-1:0]     div_remainder,
    input  logic                      div_ready
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_RESP} state_t;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                state;
    logic                  is_rem;
    logic                  cache_valid;
    logic [DATA_WIDTH-1:0] cache_q;
    logic [DATA_WIDTH-1:0] cache_r;
    logic [DATA_WIDTH-1:0] tag_rs1;
    logic [DATA_WIDTH-1:0] tag_rs2;
    logic                  tag_signed;

    logic accept;
    logic req_signed;
    logic div_zero;
    logic overflow;
    logic cache_hit;

    assign req_ready  = (state == S_IDLE);
    assign div_start  = (state == S_ISSUE) & ~flush;
    assign accept     = req_valid & req_ready & ~flush;
    assign req_signed = ~req_op[0];
    assign div_zero   = (req_rs2 == '0);
    assign overflow   = req_signed & (req_rs1 == INT_MIN) & (req_rs2 == ALL_ONES);
    assign cache_hit  = (CACHE_EN != 0) & cache_valid & (req_rs1 == tag_rs1) &
                        (req_rs2 == tag_rs2) & (req_signed == tag_signed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            is_rem       <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_rd      <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_signed   <= 1'b0;
            cache_valid  <= 1'b0;
            cache_q      <= '0;
            cache_r      <= '0;
            tag_rs1      <= '0;
            tag_rs2      <= '0;
            tag_signed   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_rem  <= req_op[1];
                        resp_rd <= req_rd;
                        if (div_zero) begin
                            resp_data  <= req_op[1] ? req_rs1 : ALL_ONES;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else if (overflow) begin
                            resp_data  <= req_op[1] ? '0 : INT_MIN;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else if (cache_hit) begin
                            resp_data  <= req_op[1] ? cache_r : cache_q;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            div_dividend <= req_rs1;
                            div_divisor  <= req_rs2;
                            div_signed   <= req_signed;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= flush ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // div_ready is a level, so a flush racing completion is still seen in DRAIN
                    if (flush) begin
                        state <= S_DRAIN;
                    end else if (div_ready) begin
                        cache_valid <= 1'b1;
                        cache_q     <= div_quotient;
                        cache_r     <= div_remainder;
                        tag_rs1     <= div_dividend;
                        tag_rs2     <= div_divisor;
                        tag_signed  <= div_signed;
                        resp_data   <= is_rem ? div_remainder : div_quotient;
                        resp_valid  <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    if (div_ready) begin
                        cache_valid <= 1'b1;
                        cache_q     <= div_quotient;
                        cache_r     <= div_remainder;
                        tag_rs1     <= div_dividend;
                        tag_rs2     <= div_divisor;
                        tag_signed  <= div_signed;
                        state       <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (flush || resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized self-checking bench for div_issue_ctrl with a 32-cycle divider model.
// Expected results come from RISC-V division rules and a last-operands cache model.
module tb_div_issue_ctrl;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_signed;
    logic [31:0] dv_q;
    logic [31:0] dv_r;
    logic        dv_ready;
    int          dv_cnt;
    int          start_cnt = 0;

    logic        nc_req_valid = 1'b0;
    logic        nc_req_ready;
    logic [1:0]  nc_req_op = 2'b00;
    logic [31:0] nc_req_rs1 = '0;
    logic [31:0] nc_req_rs2 = '0;
    logic [4:0]  nc_req_rd = '0;
    logic        nc_resp_valid;
    logic        nc_resp_ready = 1'b0;
    logic [31:0] nc_resp_data;
    logic [4:0]  nc_resp_rd;
    logic        nc_div_start;
    logic [31:0] nc_div_dividend;
    logic [31:0] nc_div_divisor;
    logic        nc_div_signed;
    logic [31:0] nc_q;
    logic [31:0] nc_r;
    logic        nc_ready;
    int          nc_cnt;
    int          nc_start_cnt = 0;

    int n_vec = 0;
    int n_miss = 0;

    // reference cache: last operands that completed a divider pass
    logic        m_valid = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_s = 1'b0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CACHE_EN(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_signed(div_signed), .div_quotient(dv_q), .div_remainder(dv_r),
        .div_ready(dv_ready)
    );

    div_issue_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CACHE_EN(0)) u_nc (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(nc_req_valid), .req_ready(nc_req_ready), .req_op(nc_req_op),
        .req_rs1(nc_req_rs1), .req_rs2(nc_req_rs2), .req_rd(nc_req_rd),
        .resp_valid(nc_resp_valid), .resp_ready(nc_resp_ready),
        .resp_data(nc_resp_data), .resp_rd(nc_resp_rd),
        .div_start(nc_div_start), .div_dividend(nc_div_dividend), .div_divisor(nc_div_divisor),
        .div_signed(nc_div_signed), .div_quotient(nc_q), .div_remainder(nc_r),
        .div_ready(nc_ready)
    );

    function automatic logic [31:0] beh_div(input logic sgn, input logic rem,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return rem ? a : ALL_ONES;
        if (sgn && a == INT_MIN && b == ALL_ONES) return rem ? 32'd0 : INT_MIN;
        sa = a;
        sb = b;
        if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
        return rem ? a % b : a / b;
    endfunction

    // 32-cycle divider models; ready is a level that drops on start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_ready <= 1'b1; dv_cnt <= 0; dv_q <= '0; dv_r <= '0;
        end else if (div_start) begin
            dv_ready <= 1'b0; dv_cnt <= 32;
            dv_q <= beh_div(div_signed, 1'b0, div_dividend, div_divisor);
            dv_r <= beh_div(div_signed, 1'b1, div_dividend, div_divisor);
        end else if (dv_cnt != 0) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1) dv_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nc_ready <= 1'b1; nc_cnt <= 0; nc_q <= '0; nc_r <= '0;
        end else if (nc_div_start) begin
            nc_ready <= 1'b0; nc_cnt <= 32;
            nc_q <= beh_div(nc_div_signed, 1'b0, nc_div_dividend, nc_div_divisor);
            nc_r <= beh_div(nc_div_signed, 1'b1, nc_div_dividend, nc_div_divisor);
        end else if (nc_cnt != 0) begin
            nc_cnt <= nc_cnt - 1;
            if (nc_cnt == 1) nc_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (div_start) start_cnt <= start_cnt + 1;
        if (nc_div_start) nc_start_cnt <= nc_start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold);
        logic [31:0] exp;
        logic        special;
        logic        hit;
        int          s0;
        int          n;
        exp     = beh_div(~op[0], op[1], a, b);
        special = (b == 32'd0) || (~op[0] && a == INT_MIN && b == ALL_ONES);
        hit     = m_valid && m_a == a && m_b == b && m_s == ~op[0];
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        s0 = start_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("latency", n, (special || hit) ? 32'd0 : 32'd34);
        chk("resp_data", resp_data, exp);
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        chk("div_starts", start_cnt - s0, (special || hit) ? 32'd0 : 32'd1);
        if (!special && !hit) begin
            m_valid = 1'b1; m_a = a; m_b = b; m_s = ~op[0];
        end
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_data", resp_data, exp);
            chk("hold_rd", {27'd0, resp_rd}, {27'd0, rd});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_drop", {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic nc_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int s0;
        int n;
        @(negedge clk);
        nc_req_valid = 1'b1; nc_req_op = op; nc_req_rs1 = a; nc_req_rs2 = b; nc_req_rd = 5'd9;
        s0 = nc_start_cnt;
        @(posedge clk);
        #1 nc_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!nc_resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("nc_resp_valid", {31'd0, nc_resp_valid}, 32'd1);
        chk("nc_resp_data", nc_resp_data, beh_div(~op[0], op[1], a, b));
        chk("nc_div_starts", nc_start_cnt - s0, 32'd1);
        nc_resp_ready = 1'b1;
        @(posedge clk);
        #1 nc_resp_ready = 1'b0;
    endtask

    initial begin
        int s0;
        int n;
        logic saw_valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
        chk("rst_dividend", div_dividend, 32'd0);
        chk("rst_divisor", div_divisor, 32'd0);
        chk("rst_signed", {31'd0, div_signed}, 32'd0);
        chk("rst_start", {31'd0, div_start}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(2'b01, 32'd100, 32'd7, 5'd5, 0);
        do_op(2'b11, 32'd100, 32'd7, 5'd6, 0);
        do_op(2'b00, 32'h1234_5678, 32'd0, 5'd1, 0);
        do_op(2'b10, 32'h1234_5678, 32'd0, 5'd2, 0);
        do_op(2'b01, 32'h1234_5678, 32'd0, 5'd3, 0);
        do_op(2'b00, INT_MIN, ALL_ONES, 5'd4, 0);
        do_op(2'b10, INT_MIN, ALL_ONES, 5'd7, 0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd9, 0);

        // flush five cycles into WAIT: divider drains, cache still refreshes
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd33; req_rd = 5'd12;
        s0 = start_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("drain_req_ready", {31'd0, req_ready}, 32'd0);
        saw_valid = 1'b0;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            saw_valid |= resp_valid;
            n++;
        end
        chk("drain_ready_back", {31'd0, req_ready}, 32'd1);
        chk("drain_div_done", {31'd0, dv_ready}, 32'd1);
        chk("drain_no_resp", {31'd0, saw_valid}, 32'd0);
        chk("drain_starts", start_cnt - s0, 32'd1);
        m_valid = 1'b1; m_a = 32'd1000; m_b = 32'd33; m_s = 1'b0;
        do_op(2'b11, 32'd1000, 32'd33, 5'd13, 0);

        do_op(2'b00, 32'd5000, 32'd3, 5'd14, 10);

        // flush in IDLE drops that cycle's request
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; req_rs1 = 32'd77; req_rs2 = 32'd0;
        s0 = start_cnt;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("idle_flush_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_flush_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_flush_starts", start_cnt - s0, 32'd0);

        // reset mid-operation clears the cache
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd900; req_rs2 = 32'd11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #2;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_dividend", div_dividend, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
        do_op(2'b01, 32'd100, 32'd7, 5'd5, 0);

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = INT_MIN; b = ALL_ONES; end
                2: begin a = m_a; b = m_b; end
                3: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            do_op(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        nc_op(2'b01, 32'd100, 32'd7);
        nc_op(2'b11, 32'd100, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Issue/response controller that sits between the execute stage and the 32-cycle multicycle divider. It accepts RISC-V M-extension DIV/DIVU/REM/REMU requests and drives the divider's start/operand interface. It selects quotient or remainder and returns the result with the destination register.
It resolves the RISC-V special cases (divide-by-zero, signed overflow) locally, and caches the last quotient/remainder pair so a DIV/REM pair on the same operands costs one divider pass.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR_WIDTH, 5, destination register index width
CACHE_EN, 1, 1 enables the last-result cache; 0 means every non-special op goes to the divider

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  pipeline flush; kills the in-flight op
req_valid  in  1  request present
req_ready  out  1  controller can accept (state==IDLE)
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_rs1  in  DATA_WIDTH  dividend
req_rs2  in  DATA_WIDTH  divisor
req_rd  in  REG_ADDR_WIDTH  destination register
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  DATA_WIDTH  result
resp_rd  out  REG_ADDR_WIDTH  destination register
div_start  out  1  one-cycle start pulse to divider
div_dividend  out  DATA_WIDTH  registered dividend to divider
div_divisor  out  DATA_WIDTH  registered divisor to divider
div_signed  out  1  registered signed_op to divider (= ~req_op[0])
div_quotient  in  DATA_WIDTH  divider quotient
div_remainder  in  DATA_WIDTH  divider remainder
div_ready  in  1  divider done; level, stays high until next start

Behaviour:
- Reset: state IDLE; resp_valid=0, resp_data=0, resp_rd=0, div_dividend=0, div_divisor=0, div_signed=0, cache_valid=0; req_ready=1; div_start=0.
- Accept: handshake is req_valid & req_ready & ~flush. Latch op, rs1, rs2 and rd. is_rem=op[1], signed=~op[0].
- Fast path on accept, checked in priority order; result is registered, and the next state is RESP with no div_start:
  1. rs2==0: DIV/DIVU give all-ones; REM/REMU give rs1.
  2. Signed, rs1==0x80000000 and rs2==0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  3. CACHE_EN, cache_valid and {rs1,rs2,signed} match the cached tag: result is the cached q or r per is_rem.
- Slow path on accept: load div_dividend/div_divisor/div_signed, go to ISSUE.
- ISSUE (1 cycle): div_start = (state==ISSUE) & ~flush, so it is high for exactly one cycle. Go to WAIT; if flush, go to IDLE without starting. div_ready is stale here and is ignored.
- WAIT: on div_ready=1, capture q/r into the cache, set the tag and cache_valid=1, register the selected result and go to RESP. Latency from start to resp_valid is divider latency +1 cycle.
- RESP: resp_valid=1. resp_data/resp_rd are held stable until resp_ready=1; then resp_valid=0 next cycle and state goes to IDLE. No new request is accepted in the same cycle as resp_ready.
- Flush:
  - IDLE: the request that cycle is ignored.
  - WAIT: go to DRAIN, because the divider cannot be aborted.
  - DRAIN: req_ready=0. On div_ready, the cache is still updated (results are operand-pure), no response is produced, state goes to IDLE.
  - RESP: drop resp_valid next cycle, go to IDLE.
- Cache is cleared only by rst. It is never loaded from fast-path cases 1 or 2.
- Only one op is in flight at a time. The divider never sees a zero divisor or the overflow case.
- Reset mid-operation: all state returns to reset values immediately. The divider shares rst.

Test Plan:
- DIVU rs1=100, rs2=7, rd=5: exactly one div_start pulse; resp_data=14, resp_rd=5 one cycle after div_ready.
- REMU rs1=100, rs2=7 immediately after the previous test: no div_start; resp_valid the cycle after accept with resp_data=2. Repeat with CACHE_EN=0: div_start pulses.
- DIV rs1=0x12345678, rs2=0: resp_data=0xFFFFFFFF. REM with the same operands: 0x12345678. DIVU with rs2=0: 0xFFFFFFFF. No div_start in any case.
- DIV 0x80000000 / 0xFFFFFFFF: 0x80000000. REM with the same operands: 0. DIV -7/2: 0xFFFFFFFD; REM: 0xFFFFFFFF (-1).
- flush asserted 5 cycles into WAIT: no resp_valid; req_ready=0 until div_ready, then 1. A following REM on the same operands hits the cache.
- resp_ready held low 10 cycles in RESP: resp_valid, resp_data and resp_rd stay stable and req_ready=0; resp_valid drops the cycle after resp_ready=1.
